// File: rtl/logic_op_pkg.sv
// Shared definitions for the logic-op datapath blocks: op encodings,
// accumulator state type and the bitwise op helper.
package logic_op_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef enum logic {
        StIdle,
        StOpen
    } acc_state_e;

    // All ops are bitwise, so a per-lane function serves any width: callers apply
    // it to each bit position of their WIDTH-bit operands.
    function automatic logic apply_op(input logic [1:0] op, input logic a, input logic b);
        logic r;
        r = 1'b0;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_op_outreg.sv
// Output register stage with valid/ready handshake. Holds its payload stable
// while the consumer stalls and reports upstream when it can take a new word.
module logic_op_outreg
    import logic_op_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Stage can load when empty or when its current word leaves this cycle
    assign o_ready = !r_valid | i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Output register: load on upstream transfer, drop valid once consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/logic_op_unit.sv
// Pipelined bitwise op unit (AND/OR/XOR/NAND) with an accumulate mode that
// folds a multi-beat packet into one result plus a saturating beat count.
module logic_op_unit
    import logic_op_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] aIn,
    input  logic [WIDTH-1:0] bIn,
    input  logic [1:0]       opSel,
    input  logic             accMode,
    input  logic             inLast,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] out,
    output logic [CNT_W-1:0] outCount,
    output logic             outOvf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int unsigned      BUS_W   = WIDTH + CNT_W + 1;

    acc_state_e       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_beat_cnt;
    logic             r_ovf;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    logic [CNT_W-1:0] r_s1_cnt;
    logic             r_s1_ovf;

    logic             w_s1_adv;
    logic             w_accept;
    logic             w_chain;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_res;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_ovf_next;
    logic [BUS_W-1:0] w_out_bus;

    assign inReady  = !r_s1_valid | w_s1_adv;
    assign w_accept = inValid & inReady;

    // Operand selection, op evaluation and beat-count update for the presented beat
    always_comb begin
        w_chain = accMode & (r_state == StOpen);
        // Continuing a packet folds the new A into the accumulator; B is ignored
        w_x     = w_chain ? r_acc : aIn;
        w_y     = w_chain ? aIn : bIn;
        w_res   = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_res[i] = apply_op(opSel, w_x[i], w_y[i]);
        end
        if (!w_chain) begin
            w_cnt_next = CNT_W'(1);
            w_ovf_next = 1'b0;
        end else if (r_beat_cnt == CNT_MAX) begin
            w_cnt_next = CNT_MAX;
            w_ovf_next = 1'b1;
        end else begin
            w_cnt_next = r_beat_cnt + CNT_W'(1);
            w_ovf_next = r_ovf;
        end
    end

    // Stage s1 and accumulator state machine, updated only on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_acc      <= '0;
            r_beat_cnt <= '0;
            r_ovf      <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_cnt   <= '0;
            r_s1_ovf   <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
            if (w_accept) begin
                if (!accMode || inLast) begin
                    r_s1_valid <= 1'b1;
                    r_s1_data  <= w_res;
                    r_s1_cnt   <= w_cnt_next;
                    r_s1_ovf   <= w_ovf_next;
                end
                if (accMode) begin
                    if (inLast) begin
                        r_state    <= StIdle;
                        r_acc      <= '0;
                        r_beat_cnt <= '0;
                        r_ovf      <= 1'b0;
                    end else begin
                        r_state    <= StOpen;
                        r_acc      <= w_res;
                        r_beat_cnt <= w_cnt_next;
                        r_ovf      <= w_ovf_next;
                    end
                end
            end
        end
    end

    logic_op_outreg #(
        .DATA_W (BUS_W)
    ) u_outreg (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_s1_valid),
        .o_ready (w_s1_adv),
        .i_data  ({r_s1_data, r_s1_cnt, r_s1_ovf}),
        .o_valid (outValid),
        .i_ready (outReady),
        .o_data  (w_out_bus)
    );

    assign {out, outCount, outOvf} = w_out_bus;

endmodule

// File: tb/tb_logic_op_unit.sv
// Directed self-checking bench for logic_op_unit. A second instance with a
// 2-bit beat counter shares the stimulus to exercise count saturation.
module tb_logic_op_unit;

    localparam logic [1:0] AND_OP  = 2'b00;
    localparam logic [1:0] OR_OP   = 2'b01;
    localparam logic [1:0] XOR_OP  = 2'b10;
    localparam logic [1:0] NAND_OP = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       inValid;
    logic [3:0] aIn;
    logic [3:0] bIn;
    logic [1:0] opSel;
    logic       accMode;
    logic       inLast;
    logic       outReady;

    logic       inReady;
    logic       outValid;
    logic [3:0] out;
    logic [3:0] outCount;
    logic       outOvf;

    logic       inReady2;
    logic       outValid2;
    logic [3:0] out2;
    logic [1:0] outCount2;
    logic       outOvf2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic_op_unit #(
        .WIDTH (4),
        .CNT_W (4)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .inValid  (inValid),
        .inReady  (inReady),
        .aIn      (aIn),
        .bIn      (bIn),
        .opSel    (opSel),
        .accMode  (accMode),
        .inLast   (inLast),
        .outValid (outValid),
        .outReady (outReady),
        .out      (out),
        .outCount (outCount),
        .outOvf   (outOvf)
    );

    logic_op_unit #(
        .WIDTH (4),
        .CNT_W (2)
    ) u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .inValid  (inValid),
        .inReady  (inReady2),
        .aIn      (aIn),
        .bIn      (bIn),
        .opSel    (opSel),
        .accMode  (accMode),
        .inLast   (inLast),
        .outValid (outValid2),
        .outReady (outReady),
        .out      (out2),
        .outCount (outCount2),
        .outOvf   (outOvf2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic acc, input logic last);
        inValid = v;
        opSel   = op;
        aIn     = a;
        bIn     = b;
        accMode = acc;
        inLast  = last;
    endtask

    task automatic idle();
        drive(1'b0, AND_OP, 4'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic [3:0] o, input logic [3:0] c,
                           input logic f);
        chk({tag, "_valid"}, {31'd0, outValid}, 32'd1);
        chk({tag, "_out"}, {28'd0, out}, {28'd0, o});
        chk({tag, "_cnt"}, {28'd0, outCount}, {28'd0, c});
        chk({tag, "_ovf"}, {31'd0, outOvf}, {31'd0, f});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] t2_exp [4];
        logic [1:0] t2_op  [4];
        logic [3:0] t5_a   [5];
        t2_exp = '{4'b1000, 4'b1110, 4'b0110, 4'b0111};
        t2_op  = '{AND_OP, OR_OP, XOR_OP, NAND_OP};
        t5_a   = '{4'b0001, 4'b0100, 4'b1000, 4'b0000, 4'b0000};

        rst      = 1'b1;
        outReady = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_valid", {31'd0, outValid}, 32'd0);
        chk("rst_out", {28'd0, out}, 32'd0);
        chk("rst_cnt", {28'd0, outCount}, 32'd0);
        chk("rst_ovf", {31'd0, outOvf}, 32'd0);
        chk("rst_inready", {31'd0, inReady}, 32'd1);
        next_cyc();

        // Standalone AND, two-cycle latency
        drive(1'b1, AND_OP, 4'b1100, 4'b1010, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_c0_valid", {31'd0, outValid}, 32'd0);
        next_cyc();
        idle();
        @(negedge clk);
        chk("t1_c1_valid", {31'd0, outValid}, 32'd0);
        next_cyc();
        @(negedge clk);
        chk_res("t1", 4'b1000, 4'd1, 1'b0);
        next_cyc();
        @(negedge clk);
        chk("t1_drained", {31'd0, outValid}, 32'd0);
        next_cyc();

        // Four ops back-to-back at full throughput
        for (int c = 0; c < 6; c++) begin
            if (c < 4) drive(1'b1, t2_op[c], 4'b1100, 4'b1010, 1'b0, 1'b0);
            else idle();
            @(negedge clk);
            if (c < 4) chk("t2_inready", {31'd0, inReady}, 32'd1);
            if (c >= 2) chk_res("t2", t2_exp[c-2], 4'd1, 1'b0);
            else chk("t2_early_valid", {31'd0, outValid}, 32'd0);
            next_cyc();
        end
        @(negedge clk);
        chk("t2_drained", {31'd0, outValid}, 32'd0);
        next_cyc();

        // Backpressure: two beats fit, third waits, nothing lost or duplicated
        outReady = 1'b0;
        drive(1'b1, AND_OP, 4'b1100, 4'b1010, 1'b0, 1'b0);
        @(negedge clk);
        chk("t3_b0_ready", {31'd0, inReady}, 32'd1);
        next_cyc();
        drive(1'b1, OR_OP, 4'b1100, 4'b1010, 1'b0, 1'b0);
        @(negedge clk);
        chk("t3_b1_ready", {31'd0, inReady}, 32'd1);
        next_cyc();
        drive(1'b1, XOR_OP, 4'b1100, 4'b1010, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("t3_stall_ready", {31'd0, inReady}, 32'd0);
            chk_res("t3_stall", 4'b1000, 4'd1, 1'b0);
            next_cyc();
        end
        outReady = 1'b1;
        @(negedge clk);
        chk("t3_release_ready", {31'd0, inReady}, 32'd1);
        chk_res("t3_r0", 4'b1000, 4'd1, 1'b0);
        next_cyc();
        idle();
        @(negedge clk);
        chk_res("t3_r1", 4'b1110, 4'd1, 1'b0);
        next_cyc();
        @(negedge clk);
        chk_res("t3_r2", 4'b0110, 4'd1, 1'b0);
        next_cyc();
        @(negedge clk);
        chk("t3_drained", {31'd0, outValid}, 32'd0);
        next_cyc();

        // Accumulate XOR over three beats
        drive(1'b1, XOR_OP, 4'b0001, 4'b0010, 1'b1, 1'b0);
        @(negedge clk);
        chk("t4_c0_valid", {31'd0, outValid}, 32'd0);
        next_cyc();
        drive(1'b1, XOR_OP, 4'b0100, 4'b1111, 1'b1, 1'b0);
        @(negedge clk);
        chk("t4_c1_valid", {31'd0, outValid}, 32'd0);
        next_cyc();
        drive(1'b1, XOR_OP, 4'b1000, 4'b1111, 1'b1, 1'b1);
        @(negedge clk);
        chk("t4_c2_valid", {31'd0, outValid}, 32'd0);
        next_cyc();
        idle();
        @(negedge clk);
        chk("t4_c3_valid", {31'd0, outValid}, 32'd0);
        next_cyc();
        @(negedge clk);
        chk_res("t4", 4'b1111, 4'd3, 1'b0);
        next_cyc();
        @(negedge clk);
        chk("t4_single", {31'd0, outValid}, 32'd0);
        next_cyc();

        // Five-beat OR packet: 2-bit counter saturates, 4-bit one does not
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, OR_OP, t5_a[i], 4'b0010, 1'b1, (i == 4));
            @(negedge clk);
            chk("t5_busy_valid2", {31'd0, outValid2}, 32'd0);
            next_cyc();
        end
        idle();
        next_cyc();
        @(negedge clk);
        chk("t5_valid2", {31'd0, outValid2}, 32'd1);
        chk("t5_out2", {28'd0, out2}, 32'h0000000f);
        chk("t5_cnt2", {30'd0, outCount2}, 32'd3);
        chk("t5_ovf2", {31'd0, outOvf2}, 32'd1);
        chk_res("t5_wide", 4'b1111, 4'd5, 1'b0);
        next_cyc();
        drive(1'b1, OR_OP, 4'b0001, 4'b0000, 1'b1, 1'b0);
        next_cyc();
        drive(1'b1, OR_OP, 4'b0010, 4'b0000, 1'b1, 1'b1);
        next_cyc();
        idle();
        next_cyc();
        @(negedge clk);
        chk("t5b_valid2", {31'd0, outValid2}, 32'd1);
        chk("t5b_out2", {28'd0, out2}, 32'h00000003);
        chk("t5b_cnt2", {30'd0, outCount2}, 32'd2);
        chk("t5b_ovf2", {31'd0, outOvf2}, 32'd0);
        next_cyc();

        // Reset in the middle of an open packet
        drive(1'b1, AND_OP, 4'b0011, 4'b0011, 1'b1, 1'b0);
        next_cyc();
        drive(1'b1, AND_OP, 4'b0011, 4'b0000, 1'b1, 1'b0);
        next_cyc();
        idle();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_valid", {31'd0, outValid}, 32'd0);
        chk("t6_rst_out", {28'd0, out}, 32'd0);
        chk("t6_rst_cnt", {28'd0, outCount}, 32'd0);
        chk("t6_rst_ovf", {31'd0, outOvf}, 32'd0);
        next_cyc();
        rst = 1'b0;
        drive(1'b1, AND_OP, 4'b1111, 4'b0101, 1'b1, 1'b1);
        next_cyc();
        idle();
        next_cyc();
        @(negedge clk);
        chk_res("t6", 4'b0101, 4'd1, 1'b0);
        chk("t6_cnt2", {30'd0, outCount2}, 32'd1);
        next_cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
